// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD display types and board-wide constants for the DE10-Standard
// seven-segment count path.
package bcd_updown_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam bcd_digit_t BCD_MAX_DIGIT       = 4'd9;
    localparam int         DEBOUNCE_20MS_50MHZ = 1_000_000;

    function automatic logic is_bcd(input bcd_pair_t v);
        return (v.tens <= BCD_MAX_DIGIT) && (v.ones <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_updown_counter_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability down-counter and a
// single-cycle pulse on each accepted press (falling edge of the debounced level).
module key_debounce
    import bcd_updown_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // The new level is taken on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync       <= 2'b11;
            level      <= 1'b1;
            press      <= 1'b0;
            stable_cnt <= RELOAD;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == level) begin
                stable_cnt <= RELOAD;
            end else if (stable_cnt == '0) begin
                level      <= sync[1];
                press      <= level;
                stable_cnt <= RELOAD;
            end else begin
                stable_cnt <= stable_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter with run/pause, load and clear keys; feeds the
// HEX1/HEX0 seven-segment decoder directly.
//
//   state | meaning
//   IDLE  | paused, prescaler holds its phase
//   RUN   | prescaler advancing, count steps on each tick
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_load_n,
    input  logic       key_clear_n,
    input  logic       up_down,
    input  logic [7:0] load_value,
    output logic [7:0] bcd_out,
    output logic       running,
    output logic       wrap,
    output logic       load_error
);

    localparam int            DIV        = CLK_HZ / TICK_HZ;
    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic start_press, load_press, clear_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .reset(reset), .key_n(key_start_n), .press(start_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk(clk), .reset(reset), .key_n(key_load_n), .press(load_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .reset(reset), .key_n(key_clear_n), .press(clear_press)
    );

    logic [8:0] sw_meta, sw_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= {up_down, load_value};
            sw_sync <= sw_meta;
        end
    end

    logic      up_sync;
    bcd_pair_t load_sync;
    assign up_sync   = sw_sync[8];
    assign load_sync = sw_sync[7:0];

    state_t        state;
    logic [PW-1:0] presc;
    bcd_pair_t     count, count_step;
    logic          step_wrap, tick;

    always_comb begin
        count_step = count;
        step_wrap  = 1'b0;
        if (up_sync) begin
            if (count.ones == BCD_MAX_DIGIT) begin
                count_step.ones = '0;
                if (count.tens == BCD_MAX_DIGIT) begin
                    count_step.tens = '0;
                    step_wrap       = 1'b1;
                end else begin
                    count_step.tens = count.tens + 1'b1;
                end
            end else begin
                count_step.ones = count.ones + 1'b1;
            end
        end else begin
            if (count.ones == '0) begin
                count_step.ones = BCD_MAX_DIGIT;
                if (count.tens == '0) begin
                    count_step.tens = BCD_MAX_DIGIT;
                    step_wrap       = 1'b1;
                end else begin
                    count_step.tens = count.tens - 1'b1;
                end
            end else begin
                count_step.ones = count.ones - 1'b1;
            end
        end
    end

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    // Event priority: clear > load > start > tick; a rejected load still drops the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            count      <= '0;
            wrap       <= 1'b0;
            load_error <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear_press) begin
                state      <= IDLE;
                presc      <= '0;
                count      <= '0;
                load_error <= 1'b0;
            end else if (load_press) begin
                if (is_bcd(load_sync)) begin
                    count      <= load_sync;
                    presc      <= '0;
                    load_error <= 1'b0;
                end else begin
                    load_error <= 1'b1;
                end
            end else if (start_press) begin
                state <= (state == IDLE) ? RUN : IDLE;
            end else if (state == RUN) begin
                if (tick) begin
                    presc <= '0;
                    count <= count_step;
                    wrap  <= step_wrap;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign bcd_out = count;
    assign running = (state == RUN);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter with DIV=10 and 4-cycle debounce.
module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] key_n = 3'b111;   // 0 start, 1 load, 2 clear
    logic       up_down = 1'b1;
    logic [7:0] load_value = 8'h00;
    logic [7:0] bcd_out;
    logic       running, wrap, load_error;

    bcd_updown_counter #(.CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .key_start_n(key_n[0]), .key_load_n(key_n[1]), .key_clear_n(key_n[2]),
        .up_down(up_down), .load_value(load_value),
        .bcd_out(bcd_out), .running(running), .wrap(wrap), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    typedef struct {
        logic [7:0] val;
        logic       wr;
        int         at;    // cycle stamp the change must appear at, -1 = any
    } exp_t;

    exp_t sb_q[$];

    task automatic expect_change(input logic [7:0] v, input logic w, input int at);
        exp_t e;
        e.val = v; e.wr = w; e.at = at;
        sb_q.push_back(e);
    endtask

    localparam int K_START = 0, K_LOAD = 1, K_CLEAR = 2;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int k);
        key_n[k] = 1'b0;
        wait_n(8);
        key_n[k] = 1'b1;
        wait_n(8);
    endtask

    // Each change of bcd_out consumes one scoreboard entry.
    logic       mon_en = 1'b0;
    logic [7:0] prev_bcd = 8'h00;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("bcd_digits", {31'd0, (bcd_out[7:4] <= 4'd9) && (bcd_out[3:0] <= 4'd9)}, 1);
            if (bcd_out !== prev_bcd) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_change", {24'd0, bcd_out}, {24'd0, prev_bcd});
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("bcd_out", {24'd0, bcd_out}, {24'd0, e.val});
                    chk("wrap", {31'd0, wrap}, {31'd0, e.wr});
                    if (e.at >= 0) chk("step_time", cyc, e.at);
                end
            end else begin
                chk("wrap_idle", {31'd0, wrap}, 0);
            end
            prev_bcd = bcd_out;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    int c0;

    initial begin
        wait_n(3);
        reset = 1'b0;
        mon_en = 1'b1;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            chk("rst_bcd", {24'd0, bcd_out}, 0);
            chk("rst_running", {31'd0, running}, 0);
            chk("rst_load_error", {31'd0, load_error}, 0);
            wait_n(1);
        end

        // Run up from 00, then asynchronous reset mid-run
        c0 = cyc;
        expect_change(8'h01, 1'b0, c0 + 17);
        expect_change(8'h02, 1'b0, c0 + 27);
        expect_change(8'h03, 1'b0, c0 + 37);
        tap(K_START);
        wait_n(24);
        chk("run_before_reset", {31'd0, running}, 1);
        expect_change(8'h00, 1'b0, -1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_bcd", {24'd0, bcd_out}, 0);
        chk("async_reset_running", {31'd0, running}, 0);
        wait_n(2);
        reset = 1'b0;

        // Bouncy load of 97, then count up through the wrap
        up_down = 1'b1;
        load_value = 8'h97;
        expect_change(8'h97, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            key_n[K_LOAD] = 1'b0;
            wait_n(2);
            key_n[K_LOAD] = 1'b1;
            wait_n(2);
        end
        tap(K_LOAD);
        chk("bounce_load", {24'd0, bcd_out}, 32'h97);
        c0 = cyc;
        expect_change(8'h98, 1'b0, c0 + 17);
        expect_change(8'h99, 1'b0, c0 + 27);
        expect_change(8'h00, 1'b1, c0 + 37);
        tap(K_START);
        wait_n(21);
        // pause lands with the prescaler at 6
        tap(K_START);
        chk("paused", {31'd0, running}, 0);
        wait_n(100);
        chk("frozen_bcd", {24'd0, bcd_out}, 0);

        // Resume: step 4 cycles after RUN; then load meets tick; then clear+load together
        c0 = cyc;
        expect_change(8'h01, 1'b0, c0 + 11);
        key_n[K_START] = 1'b0;
        wait_n(8);
        key_n[K_START] = 1'b1;
        load_value = 8'h55;
        wait_n(6);
        expect_change(8'h55, 1'b0, c0 + 21);
        key_n[K_LOAD] = 1'b0;
        wait_n(8);
        key_n[K_LOAD] = 1'b1;
        expect_change(8'h56, 1'b0, c0 + 31);
        wait_n(10);
        expect_change(8'h00, 1'b0, c0 + 39);
        key_n[K_CLEAR] = 1'b0;
        key_n[K_LOAD] = 1'b0;
        wait_n(8);
        key_n[K_CLEAR] = 1'b1;
        key_n[K_LOAD] = 1'b1;
        wait_n(10);
        chk("clear_running", {31'd0, running}, 0);
        chk("clear_bcd", {24'd0, bcd_out}, 0);

        // Load 01, count down through the wrap, flip direction mid-interval
        load_value = 8'h01;
        expect_change(8'h01, 1'b0, -1);
        tap(K_LOAD);
        up_down = 1'b0;
        c0 = cyc;
        expect_change(8'h00, 1'b0, c0 + 17);
        expect_change(8'h99, 1'b1, c0 + 27);
        expect_change(8'h98, 1'b0, c0 + 37);
        tap(K_START);
        wait_n(24);
        up_down = 1'b1;
        expect_change(8'h99, 1'b0, c0 + 47);
        wait_n(2);
        tap(K_START);
        chk("down_paused", {31'd0, running}, 0);

        // Invalid then valid load
        load_value = 8'h3A;
        tap(K_LOAD);
        chk("bad_load_error", {31'd0, load_error}, 1);
        chk("bad_load_bcd", {24'd0, bcd_out}, 32'h99);
        load_value = 8'h42;
        expect_change(8'h42, 1'b0, -1);
        tap(K_LOAD);
        chk("good_load_error", {31'd0, load_error}, 0);
        chk("good_load_bcd", {24'd0, bcd_out}, 32'h42);

        wait_n(4);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Two-digit (00–99) BCD up/down counter driven by debounced DE10-Standard pushbuttons and slide switches.
- Sits directly upstream of the board's two-digit seven-segment decoder stage.
- Its packed 8-bit BCD output {tens, ones} connects straight to that decoder's 8-bit digit input: bits [3:0] drive HEX0 and bits [7:4] drive HEX1.
- Never emits a non-BCD nibble, so the decoder's blank/default path is unreachable in normal operation.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 1, count steps per second while running; DIV = CLK_HZ/TICK_HZ, DIV must be at least 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a key level is accepted (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_start_n  in  1  pushbutton, active-low, asynchronous; each press toggles run/pause.
- key_load_n  in  1  pushbutton, active-low, asynchronous; each press loads load_value.
- key_clear_n  in  1  pushbutton, active-low, asynchronous; each press clears to 00 and pauses.
- up_down  in  1  slide switch, asynchronous; 1 = count up, 0 = count down.
- load_value  in  8  slide switches, packed BCD {tens, ones}, asynchronous.
- bcd_out  out  8  packed BCD count {tens[7:4], ones[3:0]}.
- running  out  1  1 while in RUN.
- wrap  out  1  one-cycle pulse on 99->00 (up) or 00->99 (down).
- load_error  out  1  sticky flag: last load attempt contained a non-BCD nibble.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: bcd_out=8'h00, running=0, wrap=0, load_error=0.
  - Internal: state=IDLE, prescaler=0, debouncers settle to released (1).
  - Reset mid-count discards all progress immediately.
- Input synchronization: each key, up_down and load_value bit passes through a 2-flop synchronizer.
- Debounce:
  - Each key feeds its own debouncer; the debounced level changes only after the synced input holds its new value for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the stability counter.
- Press detection: a 1->0 transition of a debounced level gives a one-cycle press pulse; releases produce nothing. Holding a key gives exactly one press.
- State machine IDLE/RUN:
  - IDLE -> RUN on start press.
  - RUN -> IDLE on start press or clear press.
  - Load does not change state.
- Prescaler:
  - Counts 0..DIV-1 only in RUN, holds in IDLE (pause/resume keeps phase).
  - Cleared to 0 by clear or accepted load.
  - tick = RUN && prescaler==DIV-1.
  - From prescaler=0, the first tick occurs on the DIV-th cycle after entering RUN.
- Count step on tick; bcd_out updates at that clock edge, registered, with no extra latency.
  - Up: ones 9 -> 0 with carry into tens; 99 -> 00 with wrap=1 for that cycle.
  - Down: ones 0 -> 9 with borrow from tens; 00 -> 99 with wrap=1.
  - up_down is sampled at the tick cycle; changing it between ticks is legal.
- Load press:
  - Both nibbles <=9: bcd_out=load_value, prescaler=0, load_error=0.
  - Otherwise: bcd_out unchanged, load_error=1.
- Clear press: bcd_out=00, state=IDLE, prescaler=0, load_error=0.
- Simultaneous events in one cycle, priority clear > load > start > tick.
  - Load coinciding with tick: the load wins and the tick is dropped.
  - Start coinciding with tick in RUN: state goes to IDLE and the tick is dropped.
- Invariant: bcd_out nibbles are always 0–9; the bench asserts this every cycle.

Decomposition:
- Shared package (board-wide):
  - BCD digit typedef (4-bit).
  - Packed two-digit typedef (8-bit).
  - State enum {IDLE, RUN}.
  - Constants BCD_MAX_DIGIT=9 and DEBOUNCE_20MS_50MHZ.
- One sub-module, key_debounce:
  - Contains the synchronizer, stability counter and falling-edge press pulse.
  - Parameterized by DEBOUNCE_CYCLES; instantiated three times.
- The counter, prescaler and FSM live in the top module.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; DEBOUNCE_CYCLES=4):
- Reset then idle 50 cycles -> bcd_out=00, running=0, wrap=0, load_error=0 throughout; assert reset mid-RUN at 37 -> bcd_out=00 asynchronously.
- load_value=8'h97, key_load_n low with 3 bounces (2-cycle glitches) then held -> exactly one load and bcd_out=97; up_down=1, start press -> 98, 99, 00 on ticks 10 cycles apart, wrap high only on the 00 cycle.
- Load 8'h01, up_down=0, run -> 00 then 99 with wrap=1, then 98; toggle up_down to 1 mid-interval -> next tick gives 99.
- Load 8'h3A -> load_error=1, bcd_out unchanged; then load 8'h42 -> load_error=0, bcd_out=42.
- Run, pause at prescaler=6, wait 100 cycles -> bcd_out frozen; resume -> next tick after 4 cycles.
- Clear and load pressed in the same cycle while running -> bcd_out=00, running=0; load and tick in the same cycle -> loaded value, no step.
